// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and default bit timing
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 217;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_CLEANUP
   } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to the idle-high line level
module sync_2ff (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and frame-error pulse
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_Frame_Err
);

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);

   logic        rx_s;
   uart_state_t state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  idx, idx_n;
   logic [7:0]  shift, shift_n;
   logic [7:0]  byte_n;
   logic        dv_n, ferr_n;
   logic        armed, armed_n;

   sync_2ff u_sync (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .d     (i_RX_Serial),
      .q     (rx_s)
   );

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         idx         <= '0;
         shift       <= '0;
         armed       <= 1'b1;
         o_RX_Byte   <= 8'h00;
         o_RX_DV     <= 1'b0;
         o_Frame_Err <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         shift       <= shift_n;
         armed       <= armed_n;
         o_RX_Byte   <= byte_n;
         o_RX_DV     <= dv_n;
         o_Frame_Err <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shift_n = shift;
      armed_n = armed;
      byte_n  = o_RX_Byte;
      dv_n    = 1'b0;
      ferr_n  = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            idx_n = '0;
            // after a framing error the line must go high before a start counts
            if (rx_s)
               armed_n = 1'b1;
            else if (armed)
               state_n = ST_START;
         end
         ST_START: begin
            if (cnt == HALF_BIT) begin
               cnt_n   = '0;
               state_n = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n        = '0;
               shift_n[idx] = rx_s;
               idx_n        = idx + 3'd1;
               if (idx == 3'd7)
                  state_n = ST_STOP;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n   = '0;
               state_n = ST_CLEANUP;
               if (rx_s) begin
                  byte_n = shift;
                  dv_n   = 1'b1;
               end else begin
                  ferr_n  = 1'b1;
                  armed_n = 1'b0;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         ST_CLEANUP: state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed bench for uart_rx with frame-level model
module tb_uart_rx;

   localparam int CPB = 8;
   localparam int LAT = 2 + (CPB - 1) / 2 + 9 * CPB + 1;

   logic       i_Clk = 1'b0;
   logic       i_Rst = 1'b1;
   logic       i_RX_Serial = 1'b1;
   logic       o_RX_DV;
   logic       o_Frame_Err;
   logic [7:0] o_RX_Byte;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clk       (i_Clk),
      .i_Rst       (i_Rst),
      .i_RX_Serial (i_RX_Serial),
      .o_RX_DV     (o_RX_DV),
      .o_RX_Byte   (o_RX_Byte),
      .o_Frame_Err (o_Frame_Err)
   );

   always #5 i_Clk = ~i_Clk;

   int cyc = 0;
   always @(posedge i_Clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         t0;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        cmp_e;
   logic [7:0] model_byte = 8'h00;
   int         checks = 0;
   int         errors = 0;
   int         dv_seen = 0;
   int         ferr_seen = 0;
   bit         chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Every pulse must match the oldest outstanding frame, within the latency window.
   always @(negedge i_Clk) begin
      if (chk_en && !i_Rst) begin
         check("dv_and_ferr_exclusive", 32'(o_RX_DV & o_Frame_Err), 32'd0);
         if (o_RX_DV || o_Frame_Err) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {30'd0, o_RX_DV, o_Frame_Err}, 32'd0);
            end else begin
               cmp_e = exp_q.pop_front();
               check("pulse_kind_is_err", 32'(o_Frame_Err), 32'(cmp_e.is_err));
               check("pulse_latency_in_window",
                     32'((cyc - cmp_e.t0 >= LAT - 1) && (cyc - cmp_e.t0 <= LAT + 2)), 32'd1);
               if (o_RX_DV) begin
                  check("rx_byte_on_dv", 32'(o_RX_Byte), 32'(cmp_e.data));
                  model_byte = cmp_e.data;
                  dv_seen++;
               end else begin
                  ferr_seen++;
               end
            end
         end else if (exp_q.size() != 0 && cyc - exp_q[0].t0 > LAT + 2) begin
            check("pulse_missing", 32'd0, 32'd1);
            void'(exp_q.pop_front());
         end
         if (!o_RX_DV)
            check("rx_byte_held", 32'(o_RX_Byte), 32'(model_byte));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_Clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      i_RX_Serial = b;
      idle(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_bit);
      ev_t e;
      e.is_err = !stop;
      e.data   = d;
      e.t0     = cyc;
      exp_q.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == rst_bit) begin
            i_RX_Serial = d[i];
            idle(CPB / 2);
            i_Rst = 1'b1;
            exp_q.delete();
            model_byte = 8'h00;
            idle(1);
            i_Rst = 1'b0;
            idle(CPB - CPB / 2 - 1);
         end else begin
            send_bit(d[i]);
         end
      end
      send_bit(stop);
      i_RX_Serial = 1'b1;
   endtask

   task automatic send_break(input int bits);
      ev_t e;
      e.is_err = 1'b1;
      e.data   = 8'h00;
      e.t0     = cyc;
      exp_q.push_back(e);
      i_RX_Serial = 1'b0;
      idle(bits * CPB);
      i_RX_Serial = 1'b1;
   endtask

   initial begin
      int dv0, ferr0;
      logic [7:0] d;
      logic       stop;

      i_Rst = 1'b1;
      idle(3);
      i_Rst = 1'b0;
      idle(1);
      check("reset_rx_byte", 32'(o_RX_Byte), 32'h00);
      check("reset_rx_dv", 32'(o_RX_DV), 32'd0);
      check("reset_frame_err", 32'(o_Frame_Err), 32'd0);
      chk_en = 1'b1;
      idle(10);

      send_frame(8'h3C, 1'b1, -1);
      idle(2 * CPB);
      check("byte_3c", 32'(o_RX_Byte), 32'h3C);
      check("dv_count_3c", 32'(dv_seen), 32'd1);
      check("ferr_count_3c", 32'(ferr_seen), 32'd0);

      send_frame(8'hA5, 1'b1, -1);
      check("byte_a5_back_to_back", 32'(o_RX_Byte), 32'hA5);
      send_frame(8'h5A, 1'b1, -1);
      idle(2 * CPB);
      check("byte_5a_back_to_back", 32'(o_RX_Byte), 32'h5A);
      check("dv_count_b2b", 32'(dv_seen), 32'd3);

      send_frame(8'h11, 1'b1, -1);
      idle(2 * CPB);
      send_frame(8'h7E, 1'b0, -1);
      idle(2 * CPB);
      check("byte_kept_11", 32'(o_RX_Byte), 32'h11);
      check("ferr_count_7e", 32'(ferr_seen), 32'd1);
      check("dv_count_7e", 32'(dv_seen), 32'd4);

      i_RX_Serial = 1'b0;
      idle(2);
      i_RX_Serial = 1'b1;
      idle(6 + 4);
      check("glitch_no_dv", 32'(dv_seen), 32'd4);
      check("glitch_no_ferr", 32'(ferr_seen), 32'd1);

      send_frame(8'hFF, 1'b1, 4);
      idle(2 * CPB);
      check("reset_mid_frame_byte", 32'(o_RX_Byte), 32'h00);
      check("reset_mid_frame_no_dv", 32'(dv_seen), 32'd4);
      send_frame(8'h42, 1'b1, -1);
      idle(2 * CPB);
      check("byte_42_after_reset", 32'(o_RX_Byte), 32'h42);

      send_break(20);
      idle(2 * CPB);
      check("break_one_ferr", 32'(ferr_seen), 32'd2);
      send_frame(8'h09, 1'b1, -1);
      idle(2 * CPB);
      check("byte_09_after_break", 32'(o_RX_Byte), 32'h09);
      check("dv_count_after_break", 32'(dv_seen), 32'd6);

      dv0   = dv_seen;
      ferr0 = ferr_seen;
      for (int k = 0; k < 16; k++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(d, stop, -1);
         idle((stop ? $urandom_range(0, 2) : $urandom_range(1, 2)) * CPB);
      end
      idle(100);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("random_pulse_total", 32'((dv_seen - dv0) + (ferr_seen - ferr0)), 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
